// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked wide adder: state encoding and index sizing.
package chunked_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // Chunk index width: clog2 of the chunk count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain WIDTH-bit ripple-carry adder; the only arithmetic in the chunked adder.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/chunked_adder.sv
// Wide adder that reuses one WIDTH-bit ripple adder over CHUNKS cycles,
// least-significant chunk first, carrying between chunks in a register.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*CHUNKS-1:0]  in_a,
    input  logic [WIDTH*CHUNKS-1:0]  in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*CHUNKS-1:0]  out_sum,
    output logic                     out_cout
);

    localparam int N  = WIDTH * CHUNKS;
    localparam int IW = idx_width(CHUNKS);
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    r_sum;
    logic            r_cout;

    logic [WIDTH-1:0] w_a_chunk;
    logic [WIDTH-1:0] w_b_chunk;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_last;

    // Chunk mux in front of the shared adder; this plus the ripple chain is the critical path.
    assign w_a_chunk = r_a[r_idx*WIDTH +: WIDTH];
    assign w_b_chunk = r_b[r_idx*WIDTH +: WIDTH];
    assign w_last    = (r_idx == LAST);

    ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state decode: accept in IDLE, step chunks in RUN, hold result in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // State, operands, inter-chunk carry and result; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*WIDTH +: WIDTH] <= w_sum;
                    r_carry                     <= w_cout;
                    // Index parks on the last chunk rather than wrapping.
                    if (w_last) r_cout <= w_cout;
                    else        r_idx  <= r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: vector table plus scoreboard, and
// hand sequences for backpressure, back-to-back, mid-run reset and CHUNKS=1.
module tb_chunked_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, out_cout;
    logic [15:0] out_sum;

    logic        in_valid1 = 1'b0, in_cin1 = 1'b0, out_ready1 = 1'b1;
    logic [3:0]  in_a1 = '0, in_b1 = '0;
    logic        in_ready1, out_valid1, out_cout1;
    logic [3:0]  out_sum1;

    int   checks = 0;
    int   failures = 0;
    res_t q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(4), .CHUNKS(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    chunked_adder #(.WIDTH(4), .CHUNKS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: a result is consumed when it is presented with out_ready high.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(out_sum), 32'hdead);
            end else begin
                res_t r;
                r = q.pop_front();
                chk("sb_sum", 32'(out_sum), 32'(r.sum));
                chk("sb_cout", 32'(out_cout), 32'(r.cout));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] es, input logic ec, input string nm);
        int   n;
        res_t r;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        r.sum = es; r.cout = ec;
        q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs after accept; they must be ignored while busy.
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        chk({nm, "_busy_in_ready"}, 32'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        chk({nm, "_latency"}, n, 4);
    endtask

    initial begin
        int          n;
        logic [16:0] s;
        logic [15:0] ra, rb;
        logic        rc;
        logic [15:0] held_sum;
        res_t        r;

        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [16:0] s;
        logic [15:0] ra, rb;
        logic        rc;
        res_t        r;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[4] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
        tbl[5] = '{16'h0FFF, 16'hF001, 1'b0, 16'h0000, 1'b1};

        // Reset state.
        #13;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_cout", 32'(out_cout), 0);
        chk("rst1_out_valid", 32'(out_valid1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            s = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            send(ra, rb, rc, s[15:0], s[16], $sformatf("rnd%0d", i));
        end

        // Backpressure: result held while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_sum", 32'(out_sum), 32'h1235);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready), 1);
        chk("bp_out_valid_after", 32'(out_valid), 0);

        // Back-to-back with in_valid held high: accepts six cycles apart.
        in_valid = 1'b1; in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0;
        r.sum = 16'h0000; r.cout = 1'b1; q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        in_a = 16'h7FFF; in_b = 16'h0001;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        chk("b2b_accept_spacing", n + 1, 6);
        r.sum = 16'h8000; r.cout = 1'b0; q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("b2b_drained", q.size(), 0);
        @(negedge clk);

        // Reset after two chunks: partial result is discarded immediately.
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        chk("mrst_out_sum", 32'(out_sum), 0);
        chk("mrst_out_cout", 32'(out_cout), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst_no_result", 32'(out_valid), 0);
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post_rst");
        n = 0;
        while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end

        // Single-chunk instance: one-cycle latency.
        @(negedge clk);
        in_valid1 = 1'b1; in_a1 = 4'hF; in_b1 = 4'h1; in_cin1 = 1'b0; out_ready1 = 1'b0;
        n = 0;
        while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("c1_valid_after_accept", 32'(out_valid1), 0);
        @(negedge clk);
        chk("c1_valid_lat1", 32'(out_valid1), 1);
        chk("c1_sum", 32'(out_sum1), 0);
        chk("c1_cout", 32'(out_cout1), 1);
        out_ready1 = 1'b1;
        @(negedge clk);
        chk("c1_in_ready_after", 32'(in_ready1), 1);

        chk("sb_empty_end", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
